// File: rtl/ram_arbiter.sv
// Purpose: round-robin arbiter sharing one synchronous RAM port between the CPU and the loader.
// Latency: request sampled in IDLE at cycle n -> write ack at n+2, read ack (with data) at n+3.
// Backpressure: req/ack handshake; a requester holds req and its operands until ack, losers wait in place.
//
// Ports:
//   clk, rst                      rising-edge clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata         CPU request and operands, held until cpu_ack
//   cpu_ack, cpu_rdata            CPU completion pulse and read data (held until next CPU read ack)
//   ldr_req/we/addr/wdata         loader request and operands, held until ldr_ack
//   ldr_ack, ldr_rdata            loader completion pulse and read data (held until next loader read ack)
//   ram_oe, ram_we                RAM read strobe / write enable, only ever high in ISSUE
//   ram_addr, ram_wdata           RAM address and write data, zero outside ISSUE
//   ram_rdata                     RAM read data, one cycle after ram_oe
//   busy                          high whenever the FSM is not in IDLE
//   owner                         current/last grant: 0 = CPU, 1 = loader
module ram_arbiter #(
    parameter int word_width = 16,
    parameter int addr_width = 10
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [addr_width-1:0] cpu_addr,
    input  logic [word_width-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [word_width-1:0] cpu_rdata,

    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [addr_width-1:0] ldr_addr,
    input  logic [word_width-1:0] ldr_wdata,
    output logic                  ldr_ack,
    output logic [word_width-1:0] ldr_rdata,

    output logic                  ram_oe,
    output logic                  ram_we,
    output logic [addr_width-1:0] ram_addr,
    output logic [word_width-1:0] ram_wdata,
    input  logic [word_width-1:0] ram_rdata,

    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RWAIT = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t state;

    // Grant decision, only consumed in IDLE. On a tie the requester that did
    // not own the previous access wins, so held requests strictly alternate.
    logic                  grant_ldr;
    logic                  any_req;
    logic                  sel_we;
    logic [addr_width-1:0] sel_addr;
    logic [word_width-1:0] sel_wdata;

    always_comb begin
        any_req   = cpu_req | ldr_req;
        grant_ldr = ldr_req & (~cpu_req | ~owner);
        sel_we    = grant_ldr ? ldr_we    : cpu_we;
        sel_addr  = grant_ldr ? ldr_addr  : cpu_addr;
        sel_wdata = grant_ldr ? ldr_wdata : cpu_wdata;
    end

    // Single-process FSM with all outputs registered. The RAM strobes are
    // loaded on the IDLE->ISSUE edge so they are high during ISSUE only, and
    // the operands are latched there so later requester changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= 1'b1;  // last grant = loader, so the CPU wins the first tie
            busy      <= 1'b0;
            cpu_ack   <= 1'b0;
            ldr_ack   <= 1'b0;
            cpu_rdata <= '0;
            ldr_rdata <= '0;
            ram_oe    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= grant_ldr;
                        busy      <= 1'b1;
                        ram_we    <= sel_we;
                        ram_oe    <= ~sel_we;
                        ram_addr  <= sel_addr;
                        ram_wdata <= sel_wdata;
                        state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    ram_we    <= 1'b0;
                    ram_oe    <= 1'b0;
                    ram_addr  <= '0;
                    ram_wdata <= '0;
                    if (ram_we) begin
                        // Write is committed at the end of this cycle; ack next.
                        if (owner) ldr_ack <= 1'b1;
                        else       cpu_ack <= 1'b1;
                        state <= ACK;
                    end else begin
                        state <= RWAIT;
                    end
                end

                RWAIT: begin
                    // RAM data is valid now; capture it so it lines up with the ack.
                    if (owner) begin
                        ldr_rdata <= ram_rdata;
                        ldr_ack   <= 1'b1;
                    end else begin
                        cpu_rdata <= ram_rdata;
                        cpu_ack   <= 1'b1;
                    end
                    state <= ACK;
                end

                ACK: begin
                    cpu_ack <= 1'b0;
                    ldr_ack <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Purpose: directed self-checking bench for ram_arbiter with a behavioural synchronous RAM.
// Latency: checks the write (2-cycle) and read (3-cycle) ack latency from request sampling.
// Backpressure: requesters hold req until ack and drop it on seeing ack.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;

    logic        ldr_req = 1'b0;
    logic        ldr_we = 1'b0;
    logic [9:0]  ldr_addr = '0;
    logic [15:0] ldr_wdata = '0;
    logic        ldr_ack;
    logic [15:0] ldr_rdata;

    logic        ram_oe;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata = '0;
    logic        busy;
    logic        owner;

    always #5 clk = ~clk;

    ram_arbiter #(.word_width(16), .addr_width(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .ldr_req   (ldr_req),
        .ldr_we    (ldr_we),
        .ldr_addr  (ldr_addr),
        .ldr_wdata (ldr_wdata),
        .ldr_ack   (ldr_ack),
        .ldr_rdata (ldr_rdata),
        .ram_oe    (ram_oe),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    // Synchronous RAM with one cycle of read latency; contents survive reset.
    logic [15:0] mem [0:1023];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_oe) ram_rdata <= mem[ram_addr];
    end

    // Event counters sampled on the active edge.
    int cpu_ack_cnt = 0;
    int ldr_ack_cnt = 0;
    int we_cnt      = 0;
    int grant_cnt   = 0;
    always @(posedge clk) begin
        if (cpu_ack)         cpu_ack_cnt <= cpu_ack_cnt + 1;
        if (ldr_ack)         ldr_ack_cnt <= ldr_ack_cnt + 1;
        if (ram_we)          we_cnt      <= we_cnt + 1;
        if (ram_we | ram_oe) grant_cnt   <= grant_cnt + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit ldr, input bit req, input bit we,
                         input logic [9:0] addr, input logic [15:0] wdata);
        if (ldr) begin
            ldr_req = req; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
        end else begin
            cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
    endtask

    // Counts edges until the chosen ack is seen; a missing ack is a failure.
    task automatic wait_ack(input bit ldr, input string tag, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 16 && !seen; i++) begin
            tick();
            cyc++;
            seen = ldr ? ldr_ack : cpu_ack;
        end
        if (!seen) chk({tag, "_ack_seen"}, {31'd0, ldr ? ldr_ack : cpu_ack}, 32'd1);
    endtask

    // Full handshake: request, wait for ack, drop req, land in IDLE.
    task automatic access(input bit ldr, input bit we, input logic [9:0] addr,
                          input logic [15:0] wdata, input string tag, output int cyc);
        drive(ldr, 1'b1, we, addr, wdata);
        wait_ack(ldr, tag, cyc);
        drive(ldr, 1'b0, 1'b0, '0, '0);
        tick();
    endtask

    initial begin
        int cyc;
        int c0, l0, w0, g0;
        int who;

        // ---- reset state ----
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_owner", {31'd0, owner}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_acks", {30'd0, cpu_ack, ldr_ack}, 32'd0);
        chk("rst_ram_ctl", {30'd0, ram_we, ram_oe}, 32'd0);
        chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
        chk("rst_rdata", {cpu_rdata, ldr_rdata}, 32'd0);

        // ---- 1: CPU write 0x1234 @0x005, then read back ----
        w0 = we_cnt;
        drive(0, 1'b1, 1'b1, 10'h005, 16'h1234);
        tick();
        chk("t1_wr_ram_we", {31'd0, ram_we}, 32'd1);
        chk("t1_wr_ram_oe", {31'd0, ram_oe}, 32'd0);
        chk("t1_wr_addr", {22'd0, ram_addr}, 32'h005);
        chk("t1_wr_wdata", {16'd0, ram_wdata}, 32'h1234);
        chk("t1_wr_owner", {31'd0, owner}, 32'd0);
        chk("t1_wr_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("t1_wr_ack", {31'd0, cpu_ack}, 32'd1);
        chk("t1_wr_ram_we_off", {31'd0, ram_we}, 32'd0);
        drive(0, 1'b0, 1'b0, '0, '0);
        tick();
        chk("t1_idle_busy", {31'd0, busy}, 32'd0);
        chk("t1_ack_pulse", {31'd0, cpu_ack}, 32'd0);
        chk("t1_we_cycles", we_cnt - w0, 32'd1);
        access(0, 1'b0, 10'h005, '0, "t1_rd", cyc);
        chk("t1_rd_latency", cyc, 32'd3);
        chk("t1_rd_data", {16'd0, cpu_rdata}, 32'h1234);
        chk("t1_no_ldr_ack", ldr_ack_cnt, 32'd0);

        // ---- 2: simultaneous requests after reset alternate C,L,C,L ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        drive(0, 1'b1, 1'b1, 10'h001, 16'h1111);
        drive(1, 1'b1, 1'b1, 10'h002, 16'h2222);
        tick();
        chk("t2_first_owner", {31'd0, owner}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            who = -1;
            for (int k = 0; k < 16 && who < 0; k++) begin
                tick();
                if (cpu_ack) who = 0;
                else if (ldr_ack) who = 1;
            end
            chk($sformatf("t2_order_%0d", i), who, i % 2);
            chk($sformatf("t2_owner_%0d", i), {31'd0, owner}, i % 2);
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        tick();

        // ---- 3: loader write 0xABCD @0x3FF while CPU waits to read it ----
        drive(1, 1'b1, 1'b1, 10'h3FF, 16'hABCD);
        tick();
        chk("t3_ldr_owner", {31'd0, owner}, 32'd1);
        drive(0, 1'b1, 1'b0, 10'h3FF, '0);
        wait_ack(1, "t3_ldr", cyc);
        chk("t3_ldr_latency", cyc, 32'd1);
        chk("t3_cpu_not_acked", {31'd0, cpu_ack}, 32'd0);
        drive(1, 1'b0, 1'b0, '0, '0);
        wait_ack(0, "t3_cpu", cyc);
        chk("t3_cpu_wait", cyc, 32'd4);
        chk("t3_cpu_data", {16'd0, cpu_rdata}, 32'hABCD);
        chk("t3_ldr_rdata_untouched", {16'd0, ldr_rdata}, 32'd0);
        drive(0, 1'b0, 1'b0, '0, '0);
        tick();

        // ---- 4: reset during RWAIT of a loader read ----
        drive(1, 1'b1, 1'b0, 10'h3FF, '0);
        tick();
        chk("t4_issue_oe", {31'd0, ram_oe}, 32'd1);
        tick();
        chk("t4_rwait_busy", {31'd0, busy}, 32'd1);
        l0 = ldr_ack_cnt;
        rst = 1'b1;
        #1;
        chk("t4_rst_oe", {31'd0, ram_oe}, 32'd0);
        chk("t4_rst_busy", {31'd0, busy}, 32'd0);
        drive(1, 1'b0, 1'b0, '0, '0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("t4_no_ldr_ack", ldr_ack_cnt - l0, 32'd0);
        chk("t4_ldr_rdata", {16'd0, ldr_rdata}, 32'd0);
        access(0, 1'b0, 10'h005, '0, "t4_cpu", cyc);
        chk("t4_cpu_latency", cyc, 32'd3);
        chk("t4_cpu_data", {16'd0, cpu_rdata}, 32'h1234);

        // ---- 5: CPU address change during ISSUE is ignored ----
        access(0, 1'b1, 10'h010, 16'h0101, "t5_wr10", cyc);
        access(1, 1'b1, 10'h020, 16'h0202, "t5_wr20", cyc);
        drive(0, 1'b1, 1'b0, 10'h010, '0);
        tick();
        chk("t5_issue_addr", {22'd0, ram_addr}, 32'h010);
        cpu_addr = 10'h020;
        wait_ack(0, "t5_rd", cyc);
        chk("t5_rd_latency", cyc, 32'd2);
        chk("t5_rd_data", {16'd0, cpu_rdata}, 32'h0101);
        drive(0, 1'b0, 1'b0, '0, '0);
        tick();

        // ---- 6: CPU holds req across ack -> back-to-back accesses ----
        c0 = cpu_ack_cnt;
        g0 = grant_cnt;
        drive(0, 1'b1, 1'b0, 10'h020, '0);
        wait_ack(0, "t6_first", cyc);
        chk("t6_first_latency", cyc, 32'd3);
        wait_ack(0, "t6_second", cyc);
        chk("t6_turnaround", cyc, 32'd4);
        drive(0, 1'b0, 1'b0, '0, '0);
        repeat (4) tick();
        chk("t6_ack_count", cpu_ack_cnt - c0, 32'd2);
        chk("t6_grant_count", grant_cnt - g0, 32'd2);
        chk("t6_rd_data", {16'd0, cpu_rdata}, 32'h0202);
        chk("t6_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
